// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell and a registered carry.
// Define SERIAL_ADDER_SUB_EN to add the sub input (result a - b, cout=1 means no borrow).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    assign w_s = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c = (r_a_sh[0] & r_b_sh[0]) |
                 (r_a_sh[0] & r_carry) |
                 (r_b_sh[0] & r_carry);

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and force a carry-in of one.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub | cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_c;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        r_cout  <= w_c;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // rst gating keeps in_ready low for the whole time reset is held.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
